// File: rtl/lobster_dbus_sequencer.sv
// Data-bus sequencer: arbitrates instruction fetch, a tagged load queue and a
// posted store buffer onto the single-port SRAM ce/we/rdy bus.
//
//   state | meaning
//   IDLE  | ce low; pick the next source (full SQ > fetch > unhazarded load > store)
//   BUSY  | ce high; command held until rdy, entry popped and response registered on rdy
module lobster_dbus_sequencer #(
    parameter int ADDR_WIDTH = 36,
    parameter int DATA_WIDTH = 64,
    parameter int LQ_DEPTH   = 8,
    parameter int SQ_DEPTH   = 8,
    parameter int TAG_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ack,
    output logic [DATA_WIDTH-1:0] fetch_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [TAG_WIDTH-1:0]  ld_tag,
    output logic                  ldr_valid,
    output logic [TAG_WIDTH-1:0]  ldr_tag,
    output logic [DATA_WIDTH-1:0] ldr_data,
    input  logic                  st_valid,
    output logic                  st_ready,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    output logic                  sq_empty,
    output logic                  ce,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  rdy
);
    localparam int LQ_PW = $clog2(LQ_DEPTH);
    localparam int SQ_PW = $clog2(SQ_DEPTH);
    localparam int LQ_CW = LQ_PW + 1;
    localparam int SQ_CW = SQ_PW + 1;

    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic [1:0] { SRC_FETCH, SRC_LOAD, SRC_STORE } src_t;

    state_t state_q, state_d;
    src_t   src_q, src_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  we_q, we_d;

    logic [ADDR_WIDTH-1:0] lq_addr_q [LQ_DEPTH];
    logic [TAG_WIDTH-1:0]  lq_tag_q  [LQ_DEPTH];
    logic [LQ_PW-1:0]      lq_head_q, lq_tail_q;
    logic [LQ_CW-1:0]      lq_cnt_q, lq_cnt_d;
    logic [ADDR_WIDTH-1:0] sq_addr_q [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] sq_data_q [SQ_DEPTH];
    logic [SQ_PW-1:0]      sq_head_q, sq_tail_q;
    logic [SQ_CW-1:0]      sq_cnt_q, sq_cnt_d;
    logic                  ld_ready_q, st_ready_q, sq_empty_q;

    logic lq_push, lq_pop, sq_push, sq_pop, fetch_done, load_done;
    logic sq_full, hazard;
    logic [SQ_DEPTH-1:0] sq_match;

    logic                  fetch_ack_q, ldr_valid_q;
    logic [DATA_WIDTH-1:0] fetch_data_q, ldr_data_q;
    logic [TAG_WIDTH-1:0]  ldr_tag_q;

    assign lq_push = ld_valid & ld_ready_q;
    assign sq_push = st_valid & st_ready_q;
    assign sq_full = (sq_cnt_q == SQ_CW'(SQ_DEPTH));
    assign lq_cnt_d = lq_cnt_q + LQ_CW'(lq_push) - LQ_CW'(lq_pop);
    assign sq_cnt_d = sq_cnt_q + SQ_CW'(sq_push) - SQ_CW'(sq_pop);

    // An SQ slot takes part in the hazard check only while it holds a live
    // entry, including the one currently on the bus.
    for (genvar g = 0; g < SQ_DEPTH; g++) begin : g_haz
        logic [SQ_PW-1:0] off;
        assign off         = SQ_PW'(g) - sq_head_q;
        assign sq_match[g] = ({1'b0, off} < sq_cnt_q) &&
                             (sq_addr_q[g] == lq_addr_q[lq_head_q]);
    end
    assign hazard = |sq_match;

    // Queue entry storage; contents are don't-care outside the live window.
    always_ff @(posedge clk) begin
        if (lq_push) begin
            lq_addr_q[lq_tail_q] <= ld_addr;
            lq_tag_q[lq_tail_q]  <= ld_tag;
        end
        if (sq_push) begin
            sq_addr_q[sq_tail_q] <= st_addr;
            sq_data_q[sq_tail_q] <= st_data;
        end
    end

    // Queue pointers, counts and registered ready/empty flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            lq_head_q  <= '0;
            lq_tail_q  <= '0;
            lq_cnt_q   <= '0;
            sq_head_q  <= '0;
            sq_tail_q  <= '0;
            sq_cnt_q   <= '0;
            ld_ready_q <= 1'b1;
            st_ready_q <= 1'b1;
            sq_empty_q <= 1'b1;
        end else begin
            lq_head_q  <= lq_head_q + LQ_PW'(lq_pop);
            lq_tail_q  <= lq_tail_q + LQ_PW'(lq_push);
            lq_cnt_q   <= lq_cnt_d;
            sq_head_q  <= sq_head_q + SQ_PW'(sq_pop);
            sq_tail_q  <= sq_tail_q + SQ_PW'(sq_push);
            sq_cnt_q   <= sq_cnt_d;
            ld_ready_q <= (lq_cnt_d != LQ_CW'(LQ_DEPTH));
            st_ready_q <= (sq_cnt_d != SQ_CW'(SQ_DEPTH));
            sq_empty_q <= (sq_cnt_d == '0);
        end
    end

    // Bus FSM state and held command registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            src_q       <= SRC_FETCH;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            we_q        <= we_d;
        end
    end

    // Arbitration in IDLE, completion and pops in BUSY. Fetch is ignored in the
    // ack cycle so a requester still holding fetch_req is not served twice.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        we_d        = we_q;
        lq_pop      = 1'b0;
        sq_pop      = 1'b0;
        fetch_done  = 1'b0;
        load_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sq_full) begin
                    state_d = BUSY; src_d = SRC_STORE; we_d = 1'b1;
                    mem_addr_d = sq_addr_q[sq_head_q]; mem_wdata_d = sq_data_q[sq_head_q];
                end else if (fetch_req && !fetch_ack_q) begin
                    state_d = BUSY; src_d = SRC_FETCH; we_d = 1'b0;
                    mem_addr_d = fetch_addr;
                end else if ((lq_cnt_q != '0) && !hazard) begin
                    state_d = BUSY; src_d = SRC_LOAD; we_d = 1'b0;
                    mem_addr_d = lq_addr_q[lq_head_q];
                end else if (sq_cnt_q != '0) begin
                    state_d = BUSY; src_d = SRC_STORE; we_d = 1'b1;
                    mem_addr_d = sq_addr_q[sq_head_q]; mem_wdata_d = sq_data_q[sq_head_q];
                end
            end
            BUSY: begin
                if (rdy) begin
                    state_d = IDLE;
                    case (src_q)
                        SRC_FETCH: fetch_done = 1'b1;
                        SRC_LOAD:  begin load_done = 1'b1; lq_pop = 1'b1; end
                        SRC_STORE: sq_pop = 1'b1;
                        default:   state_d = IDLE;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered completion pulses and response data.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_ack_q  <= 1'b0;
            ldr_valid_q  <= 1'b0;
            fetch_data_q <= '0;
            ldr_data_q   <= '0;
            ldr_tag_q    <= '0;
        end else begin
            fetch_ack_q <= fetch_done;
            ldr_valid_q <= load_done;
            if (fetch_done) fetch_data_q <= mem_rdata;
            if (load_done) begin
                ldr_data_q <= mem_rdata;
                ldr_tag_q  <= lq_tag_q[lq_head_q];
            end
        end
    end

    assign ce         = (state_q == BUSY);
    assign we         = ce & we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fetch_ack  = fetch_ack_q;
    assign fetch_data = fetch_data_q;
    assign ldr_valid  = ldr_valid_q;
    assign ldr_tag    = ldr_tag_q;
    assign ldr_data   = ldr_data_q;
    assign ld_ready   = ld_ready_q;
    assign st_ready   = st_ready_q;
    assign sq_empty   = sq_empty_q;
endmodule
